// File: rtl/vga_fb_controller.sv
// Frame buffer write-port controller: arbitrates host pixel writes against a full-screen fill, and stages colour changes to VS edges.
// Latency: a pixel request shows on FB_* one cycle later; a fill issues its first write one cycle after the start and then one write per cycle.
// Backpressure: one pixel write per two cycles, and requests wait while a fill runs; a colour word waits in a pending register until the next VS rise.
module vga_fb_controller #(
    parameter int          X_MAX           = 159,
    parameter int          Y_MAX           = 119,
    parameter logic [15:0] DEFAULT_COLOURS = 16'hFF00
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_wr_req_i,
    input  logic [7:0]  pix_x_i,
    input  logic [6:0]  pix_y_i,
    input  logic        pix_data_i,
    output logic        pix_wr_ack_o,
    input  logic        fill_start_i,
    input  logic        fill_value_i,
    output logic        fill_busy_o,
    output logic        fill_done_o,
    input  logic        colour_wr_i,
    input  logic [15:0] colour_in_i,
    input  logic        vga_vs_i,
    output logic [15:0] config_colours_o,
    output logic        fb_we_o,
    output logic [14:0] fb_addr_o,
    output logic        fb_data_o
);

    typedef enum logic [1:0] {IDLE, PIX_ACK, FILL, DONE} state_e;

    localparam logic [7:0] XM = 8'(X_MAX);
    localparam logic [6:0] YM = 7'(Y_MAX);

    state_e      state_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic        fill_val_q;
    logic        pix_ack_q;
    logic        fill_busy_q;
    logic        fill_done_q;
    logic        fb_we_q;
    logic [14:0] fb_addr_q;
    logic        fb_data_q;

    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        vs_q;
    logic [15:0] colours_q, colours_d;

    logic        pix_in_range;
    logic        fill_last;
    logic        vs_rise;

    assign pix_in_range = (pix_x_i <= XM) && (pix_y_i <= YM);
    assign fill_last    = (x_q == XM) && (y_q == YM);
    assign vs_rise      = vga_vs_i && !vs_q;

    // Write-port sequencer; every output is registered and follows the state it enters.
    // x_q/y_q always hold the address currently presented during a fill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            fill_val_q  <= 1'b0;
            pix_ack_q   <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pix_ack_q   <= 1'b0;
                    fb_we_q     <= 1'b0;
                    fill_done_q <= 1'b0;
                    if (fill_start_i) begin
                        // Fill wins over a simultaneous pixel request; that request stays pending.
                        state_q     <= FILL;
                        fill_val_q  <= fill_value_i;
                        x_q         <= '0;
                        y_q         <= '0;
                        fill_busy_q <= 1'b1;
                        fb_we_q     <= 1'b1;
                        fb_addr_q   <= '0;
                        fb_data_q   <= fill_value_i;
                    end else if (pix_wr_req_i) begin
                        // Out-of-range pixels are acknowledged but never written.
                        state_q   <= PIX_ACK;
                        pix_ack_q <= 1'b1;
                        fb_we_q   <= pix_in_range;
                        fb_addr_q <= {pix_y_i, pix_x_i};
                        fb_data_q <= pix_data_i;
                    end
                end
                PIX_ACK: begin
                    state_q   <= IDLE;
                    pix_ack_q <= 1'b0;
                    fb_we_q   <= 1'b0;
                end
                FILL: begin
                    if (fill_last) begin
                        state_q     <= DONE;
                        fb_we_q     <= 1'b0;
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b1;
                    end else if (x_q == XM) begin
                        x_q       <= '0;
                        y_q       <= y_q + 7'd1;
                        fb_addr_q <= {y_q + 7'd1, 8'd0};
                    end else begin
                        x_q       <= x_q + 8'd1;
                        fb_addr_q <= {y_q, x_q + 8'd1};
                    end
                    fb_data_q <= fill_val_q;
                end
                DONE: begin
                    state_q     <= IDLE;
                    fill_done_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Colour staging: an edge commits only what was pending before this cycle; a same-cycle write becomes the new pending word.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        colours_d  = colours_q;
        if (vs_rise && pend_vld_q) begin
            colours_d  = pend_q;
            pend_vld_d = 1'b0;
        end
        if (colour_wr_i) begin
            pend_d     = colour_in_i;
            pend_vld_d = 1'b1;
        end
    end

    // Colour registers; vs_q resets high so releasing reset with VS high is not an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            vs_q       <= 1'b1;
            colours_q  <= DEFAULT_COLOURS;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            vs_q       <= vga_vs_i;
            colours_q  <= colours_d;
        end
    end

    assign pix_wr_ack_o     = pix_ack_q;
    assign fill_busy_o      = fill_busy_q;
    assign fill_done_o      = fill_done_q;
    assign fb_we_o          = fb_we_q;
    assign fb_addr_o        = fb_addr_q;
    assign fb_data_o        = fb_data_q;
    assign config_colours_o = colours_q;

endmodule

// File: tb/tb_vga_fb_controller.sv
// Directed bench for vga_fb_controller: reset, pixel writes, fill sweep, contention, colour staging, async reset mid-fill.
// Inputs driven on the falling edge, outputs sampled on the falling edge after the rising edge of interest.
// Reports one FAIL line per failed comparison and a single summary line.
module tb_vga_fb_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_wr_req;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic        pix_data;
    logic        pix_wr_ack;
    logic        fill_start;
    logic        fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic        colour_wr;
    logic [15:0] colour_in;
    logic        vga_vs;
    logic [15:0] config_colours;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic        fb_data;

    int checks   = 0;
    int failures = 0;

    vga_fb_controller dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pix_wr_req_i     (pix_wr_req),
        .pix_x_i          (pix_x),
        .pix_y_i          (pix_y),
        .pix_data_i       (pix_data),
        .pix_wr_ack_o     (pix_wr_ack),
        .fill_start_i     (fill_start),
        .fill_value_i     (fill_value),
        .fill_busy_o      (fill_busy),
        .fill_done_o      (fill_done),
        .colour_wr_i      (colour_wr),
        .colour_in_i      (colour_in),
        .vga_vs_i         (vga_vs),
        .config_colours_o (config_colours),
        .fb_we_o          (fb_we),
        .fb_addr_o        (fb_addr),
        .fb_data_o        (fb_data)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; pix_wr_req = 0; pix_x = 0; pix_y = 0; pix_data = 0;
        fill_start = 0; fill_value = 0; colour_wr = 0; colour_in = 0; vga_vs = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({fb_we, fb_addr, fb_data, pix_wr_ack, fill_busy, fill_done} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs got we=%b addr=%h data=%b ack=%b busy=%b done=%b want all 0",
                     fb_we, fb_addr, fb_data, pix_wr_ack, fill_busy, fill_done);
        end
        checks++;
        if (config_colours !== 16'hFF00) begin
            failures++;
            $display("FAIL reset_colours got %h want ff00", config_colours);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (config_colours !== 16'hFF00 || fb_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got colours=%h we=%b want ff00 0", config_colours, fb_we);
        end
        vga_vs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pixel_write();
        pix_wr_req = 1; pix_x = 8'd5; pix_y = 7'd3; pix_data = 1;
        @(negedge clk);
        pix_wr_req = 0;
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 15'h0305 || fb_data !== 1'b1 || pix_wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL pixel_write got we=%b addr=%h data=%b ack=%b want 1 0305 1 1",
                     fb_we, fb_addr, fb_data, pix_wr_ack);
        end
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || pix_wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL pixel_single got we=%b ack=%b want 0 0", fb_we, pix_wr_ack);
        end
        // Last valid pixel with data 0.
        pix_wr_req = 1; pix_x = 8'd159; pix_y = 7'd119; pix_data = 0;
        @(negedge clk);
        pix_wr_req = 0;
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 15'h779F || fb_data !== 1'b0 || pix_wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL pixel_corner got we=%b addr=%h data=%b ack=%b want 1 779f 0 1",
                     fb_we, fb_addr, fb_data, pix_wr_ack);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        pix_wr_req = 1; pix_x = 8'd5; pix_y = 7'd3; pix_data = 1;
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b1 || pix_wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got we=%b ack=%b want 1 1", fb_we, pix_wr_ack);
        end
        @(negedge clk);
        checks++;
        if (fb_we !== 1'b0 || pix_wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got we=%b ack=%b want 0 0", fb_we, pix_wr_ack);
        end
        @(negedge clk);
        pix_wr_req = 0;
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 15'h0305 || pix_wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second got we=%b addr=%h ack=%b want 1 0305 1", fb_we, fb_addr, pix_wr_ack);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        logic [7:0] xs [2];
        logic [6:0] ys [2];
        xs[0] = 8'd160; ys[0] = 7'd0;
        xs[1] = 8'd0;   ys[1] = 7'd120;
        for (int i = 0; i < 2; i++) begin
            pix_wr_req = 1; pix_x = xs[i]; pix_y = ys[i]; pix_data = 1;
            @(negedge clk);
            pix_wr_req = 0;
            checks++;
            if (fb_we !== 1'b0 || pix_wr_ack !== 1'b1) begin
                failures++;
                $display("FAIL oor_%0d got we=%b ack=%b want 0 1", i, fb_we, pix_wr_ack);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fill();
        int bad = 0;
        fill_start = 1; fill_value = 1;
        @(negedge clk);
        fill_start = 0; fill_value = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                checks++;
                if (fb_we !== 1'b1 || fb_data !== 1'b1 || fill_busy !== 1'b1 || fill_done !== 1'b0 ||
                    fb_addr !== {y[6:0], x[7:0]}) begin
                    failures++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL fill_write got we=%b data=%b busy=%b done=%b addr=%h want 1 1 1 0 %h",
                                 fb_we, fb_data, fill_busy, fill_done, fb_addr, {y[6:0], x[7:0]});
                end
                @(negedge clk);
            end
        end
        checks++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b0 || fb_we !== 1'b0) begin
            failures++;
            $display("FAIL fill_done got done=%b busy=%b we=%b want 1 0 0", fill_done, fill_busy, fb_we);
        end
        @(negedge clk);
        checks++;
        if (fill_done !== 1'b0 || fb_we !== 1'b0) begin
            failures++;
            $display("FAIL fill_done_pulse got done=%b we=%b want 0 0", fill_done, fb_we);
        end
    endtask

    task automatic test_contention();
        int bad = 0;
        fill_start = 1; fill_value = 0;
        pix_wr_req = 1; pix_x = 8'd1; pix_y = 7'd1; pix_data = 1;
        @(negedge clk);
        fill_start = 0;
        for (int i = 0; i < 19200; i++) begin
            checks++;
            if (pix_wr_ack !== 1'b0 || fill_busy !== 1'b1 || fb_we !== 1'b1 || fb_data !== 1'b0) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL cont_fill cycle=%0d got ack=%b busy=%b we=%b data=%b want 0 1 1 0",
                             i, pix_wr_ack, fill_busy, fb_we, fb_data);
            end
            @(negedge clk);
        end
        checks++;
        if (fill_done !== 1'b1 || pix_wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL cont_done got done=%b ack=%b want 1 0", fill_done, pix_wr_ack);
        end
        @(negedge clk);
        checks++;
        if (pix_wr_ack !== 1'b0 || fb_we !== 1'b0) begin
            failures++;
            $display("FAIL cont_idle got ack=%b we=%b want 0 0", pix_wr_ack, fb_we);
        end
        @(negedge clk);
        pix_wr_req = 0;
        checks++;
        if (pix_wr_ack !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 15'h0101 || fb_data !== 1'b1) begin
            failures++;
            $display("FAIL cont_pixel got ack=%b we=%b addr=%h data=%b want 1 1 0101 1",
                     pix_wr_ack, fb_we, fb_addr, fb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_colour();
        colour_wr = 1; colour_in = 16'h1C03;
        @(negedge clk);
        colour_wr = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (config_colours !== 16'hFF00) begin
            failures++;
            $display("FAIL colour_hold got %h want ff00", config_colours);
        end
        vga_vs = 1;
        @(negedge clk);
        checks++;
        if (config_colours !== 16'h1C03) begin
            failures++;
            $display("FAIL colour_commit got %h want 1c03", config_colours);
        end
        repeat (2) @(negedge clk);
        vga_vs = 0;
        repeat (2) @(negedge clk);
        // Write on the edge cycle: nothing pending before, so nothing commits now.
        vga_vs = 1; colour_wr = 1; colour_in = 16'hE0FF;
        @(negedge clk);
        colour_wr = 0;
        checks++;
        if (config_colours !== 16'h1C03) begin
            failures++;
            $display("FAIL colour_same_edge got %h want 1c03", config_colours);
        end
        repeat (2) @(negedge clk);
        vga_vs = 0;
        repeat (2) @(negedge clk);
        vga_vs = 1;
        @(negedge clk);
        checks++;
        if (config_colours !== 16'hE0FF) begin
            failures++;
            $display("FAIL colour_next_edge got %h want e0ff", config_colours);
        end
        vga_vs = 0;
        colour_wr = 1; colour_in = 16'hAAAA;
        @(negedge clk);
        colour_in = 16'h5555;
        @(negedge clk);
        colour_wr = 0;
        vga_vs = 1;
        @(negedge clk);
        checks++;
        if (config_colours !== 16'h5555) begin
            failures++;
            $display("FAIL colour_last_wins got %h want 5555", config_colours);
        end
        vga_vs = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        fill_start = 1; fill_value = 1;
        @(negedge clk);
        fill_start = 0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fb_we !== 1'b0 || fill_busy !== 1'b0 || fb_addr !== 15'd0 || config_colours !== 16'hFF00) begin
            failures++;
            $display("FAIL async_reset got we=%b busy=%b addr=%h colours=%h want 0 0 0000 ff00",
                     fb_we, fill_busy, fb_addr, config_colours);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (fill_done !== 1'b0 || fb_we !== 1'b0) begin
                failures++;
                $display("FAIL abandoned_fill cycle=%0d got done=%b we=%b want 0 0", i, fill_done, fb_we);
            end
        end
        pix_wr_req = 1; pix_x = 8'd7; pix_y = 7'd2; pix_data = 1;
        @(negedge clk);
        pix_wr_req = 0;
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 15'h0207 || pix_wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_pixel got we=%b addr=%h ack=%b want 1 0207 1", fb_we, fb_addr, pix_wr_ack);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_pixel_write();
        test_back_to_back();
        test_out_of_range();
        test_fill();
        test_contention();
        test_colour();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
